// File: rtl/ucsbece152a_counter_ctrl_pkg.sv
// rtl/ucsbece152a_counter_ctrl_pkg.sv - shared state type and direction encoding for the button controller
package ucsbece152a_counter_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    HELD_UP   = 2'd1,
    HELD_DOWN = 2'd2,
    LOCK      = 2'd3
  } ctrl_state_t;

  // Matches the counter's direction input: 0 increments, 1 decrements.
  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/ucsbece152a_debounce.sv
// rtl/ucsbece152a_debounce.sv - 2-flop synchronizer and stable-count debouncer for one raw button
module ucsbece152a_debounce
  import ucsbece152a_counter_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o
);

  localparam logic [15:0] CNT_MAX = 16'(DEBOUNCE_CYCLES);

  logic [1:0]  sync_q, sync_d;
  logic        level_q, level_d;
  logic        rise_q, rise_d;
  logic [15:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q  <= sync_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  // The level flips on the edge after the count has reached its limit.
  always_comb begin
    sync_d  = {sync_q[0], raw_i};
    level_d = level_q;
    rise_d  = 1'b0;
    cnt_d   = '0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CNT_MAX) begin
        level_d = sync_q[1];
        rise_d  = sync_q[1];
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;

endmodule

// File: rtl/ucsbece152a_counter_ctrl.sv
// rtl/ucsbece152a_counter_ctrl.sv - turns two bouncy buttons into counter enable/direction; COUNTER_CTRL_AUTOREPEAT_EN adds hold-to-repeat
module ucsbece152a_counter_ctrl
  import ucsbece152a_counter_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 8,
  parameter int unsigned REPEAT_DELAY    = 16,
  parameter int unsigned REPEAT_PERIOD   = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_up_i,
  input  logic btn_down_i,
  output logic enable_o,
  output logic dir_o,
  output logic locked_o
);

  // Repeat spacing below 2 would make enable_o high on consecutive cycles.
  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535 ||
      REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_param_check
    $error("ucsbece152a_counter_ctrl: illegal parameter value");
  end

  logic db_up, db_down, rise_up, rise_down;

  ucsbece152a_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
    .clk     (clk),
    .rst     (rst),
    .raw_i   (btn_up_i),
    .level_o (db_up),
    .rise_o  (rise_up)
  );

  ucsbece152a_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
    .clk     (clk),
    .rst     (rst),
    .raw_i   (btn_down_i),
    .level_o (db_down),
    .rise_o  (rise_down)
  );

  ctrl_state_t state_q, state_d;
  logic        enable_q, enable_d;
  logic        dir_q, dir_d;
  logic        rpt_fire;

`ifdef COUNTER_CTRL_AUTOREPEAT_EN
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);
  localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

  logic [RPT_W-1:0] rpt_q, rpt_d;
  logic             rpt_armed_q, rpt_armed_d;
  logic             held_stay;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rpt_q       <= '0;
      rpt_armed_q <= 1'b0;
    end else begin
      rpt_q       <= rpt_d;
      rpt_armed_q <= rpt_armed_d;
    end
  end

  // rpt_armed_q marks that the long first delay is over; later gaps use the period.
  assign rpt_fire  = rpt_armed_q ? (rpt_q == PERIOD_LAST) : (rpt_q == DELAY_LAST);
  assign held_stay = ((state_q == HELD_UP) || (state_q == HELD_DOWN)) && (state_d == state_q);

  always_comb begin
    rpt_d       = '0;
    rpt_armed_d = 1'b0;
    if (held_stay) begin
      if (rpt_fire) begin
        rpt_armed_d = 1'b1;
      end else begin
        rpt_d       = rpt_q + 1'b1;
        rpt_armed_d = rpt_armed_q;
      end
    end
  end
`else
  assign rpt_fire = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      enable_q <= 1'b0;
      dir_q    <= DIR_UP;
    end else begin
      state_q  <= state_d;
      enable_q <= enable_d;
      dir_q    <= dir_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    enable_d = 1'b0;
    dir_d    = dir_q;
    unique case (state_q)
      IDLE: begin
        if (rise_up && rise_down) begin
          state_d = LOCK;
        end else if (rise_up && !db_down) begin
          state_d  = HELD_UP;
          enable_d = 1'b1;
          dir_d    = DIR_UP;
        end else if (rise_down && !db_up) begin
          state_d  = HELD_DOWN;
          enable_d = 1'b1;
          dir_d    = DIR_DOWN;
        end
      end
      HELD_UP: begin
        if (db_down) begin
          state_d = LOCK;
        end else if (!db_up) begin
          state_d = IDLE;
        end else if (rpt_fire) begin
          enable_d = 1'b1;
        end
      end
      HELD_DOWN: begin
        if (db_up) begin
          state_d = LOCK;
        end else if (!db_down) begin
          state_d = IDLE;
        end else if (rpt_fire) begin
          enable_d = 1'b1;
        end
      end
      LOCK: begin
        // A button still held after the other lets go must be re-pressed from IDLE.
        if (!db_up && !db_down) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign enable_o = enable_q;
  assign dir_o    = dir_q;
  assign locked_o = (state_q == LOCK);

endmodule

// File: tb/tb_ucsbece152a_counter_ctrl.sv
// tb/tb_ucsbece152a_counter_ctrl.sv - scoreboard bench for the button-to-counter controller
`timescale 1ns/1ps
module tb_ucsbece152a_counter_ctrl;

  localparam int N  = 4;
  localparam int RD = 16;
  localparam int RP = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_up_i = 1'b0;
  logic btn_down_i = 1'b0;
  logic enable_o, dir_o, locked_o;

  always #5 clk = ~clk;

  ucsbece152a_counter_ctrl #(
    .DEBOUNCE_CYCLES (N),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_up_i   (btn_up_i),
    .btn_down_i (btn_down_i),
    .enable_o   (enable_o),
    .dir_o      (dir_o),
    .locked_o   (locked_o)
  );

  typedef struct {
    int   cyc;
    logic dir;
  } pulse_t;

  pulse_t exp_q[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int pulses_seen = 0;
  logic [2:0] cnt_act = 3'd0;
  logic prev_en = 1'b0;

  // Reference model state: raw samples since reset, debounced levels, press owner.
  logic hist_u[$];
  logic hist_d[$];
  logic m_db_u = 1'b0, m_db_d = 1'b0, m_rise_u = 1'b0, m_rise_d = 1'b0;
  logic m_dir = 1'b0, m_locked = 1'b0;
  int   m_owner = 0;  // 0 none, 1 up, 2 down, 3 locked out
  int   m_p0 = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // A level changes once the last N+1 synchronized samples all disagree with it;
  // the synchronized value at an edge is the raw sample from two edges earlier.
  function automatic logic win_diff(input bit which, input logic db);
    int sz;
    logic v;
    sz = which ? hist_d.size() : hist_u.size();
    for (int k = 0; k <= N; k++) begin
      int idx;
      idx = sz - 2 - k;
      if (idx < 0) v = 1'b0;
      else v = which ? hist_d[idx] : hist_u[idx];
      if (v == db) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic emit(input logic d);
    pulse_t p;
    p.cyc = cyc;
    p.dir = d;
    exp_q.push_back(p);
    m_dir = d;
  endtask

  always @(posedge clk) begin
    logic fu, fd;
    cyc++;
    if (rst) begin
      hist_u.delete();
      hist_d.delete();
      exp_q.delete();
      m_db_u = 1'b0; m_db_d = 1'b0; m_rise_u = 1'b0; m_rise_d = 1'b0;
      m_dir = 1'b0; m_locked = 1'b0; m_owner = 0;
    end else begin
      case (m_owner)
        0: begin
          if (m_rise_u && m_rise_d) m_owner = 3;
          else if (m_rise_u && !m_db_d) begin emit(1'b0); m_owner = 1; m_p0 = cyc; end
          else if (m_rise_d && !m_db_u) begin emit(1'b1); m_owner = 2; m_p0 = cyc; end
        end
        1, 2: begin
          logic mine, other;
          mine  = (m_owner == 1) ? m_db_u : m_db_d;
          other = (m_owner == 1) ? m_db_d : m_db_u;
          if (other) m_owner = 3;
          else if (!mine) m_owner = 0;
`ifdef COUNTER_CTRL_AUTOREPEAT_EN
          else if ((cyc - m_p0 == RD) || (cyc - m_p0 > RD && (cyc - m_p0 - RD) % RP == 0))
            emit(m_owner == 2);
`endif
        end
        default: if (!m_db_u && !m_db_d) m_owner = 0;
      endcase
      fu = win_diff(1'b0, m_db_u);
      fd = win_diff(1'b1, m_db_d);
      m_rise_u = fu && !m_db_u;
      m_rise_d = fd && !m_db_d;
      if (fu) m_db_u = ~m_db_u;
      if (fd) m_db_d = ~m_db_d;
      hist_u.push_back(btn_up_i);
      hist_d.push_back(btn_down_i);
      if (hist_u.size() > N + 8) begin
        void'(hist_u.pop_front());
        void'(hist_d.pop_front());
      end
      m_locked = (m_owner == 3);
    end
  end

  // Monitor: compares DUT outputs at the falling edge against the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      check("rst_enable", enable_o, 0);
      check("rst_dir", dir_o, 0);
      check("rst_locked", locked_o, 0);
      cnt_act = 3'd0;
      prev_en = 1'b0;
    end else begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        check("missed_pulse_cycle", cyc, exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
      if (enable_o) begin
        pulses_seen++;
        cnt_act = dir_o ? cnt_act - 3'd1 : cnt_act + 3'd1;
        check("no_back_to_back", prev_en, 0);
        check("pulse_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          pulse_t p;
          p = exp_q.pop_front();
          check("pulse_cycle", cyc, p.cyc);
          check("pulse_dir", dir_o, p.dir);
        end
      end
      check("locked", locked_o, m_locked);
      check("dir_hold", dir_o, m_dir);
      prev_en = enable_o;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  int base;
  int exp_rpt;

  initial begin
    // Reset with both buttons held: nothing moves until release.
    btn_up_i = 1'b1; btn_down_i = 1'b1; rst = 1'b1;
    tick(3);
    btn_down_i = 1'b0; rst = 1'b0;
    base = pulses_seen;
    tick(12);
    check("after_reset_pulses", pulses_seen - base, 1);
    btn_up_i = 1'b0;
    tick(10);

    // Five clean up presses.
    do_reset();
    base = pulses_seen;
    repeat (5) begin
      btn_up_i = 1'b1; tick(12);
      btn_up_i = 1'b0; tick(10);
    end
    check("five_up_pulses", pulses_seen - base, 5);
    check("five_up_count", cnt_act, 5);

    // Bouncing down button, then settled: one step down wraps 0 to 7.
    do_reset();
    base = pulses_seen;
    btn_down_i = 1'b1; tick(1);
    btn_down_i = 1'b0; tick(1);
    btn_down_i = 1'b1; tick(1);
    btn_down_i = 1'b0; tick(1);
    btn_down_i = 1'b1; tick(14);
    check("bounce_pulses", pulses_seen - base, 1);
    check("bounce_wrap_count", cnt_act, 7);
    btn_down_i = 1'b0; tick(10);

    // Lockout entered from a held press, left only after both release.
    base = pulses_seen;
    btn_up_i = 1'b1; tick(12);
    btn_down_i = 1'b1; tick(10);
    check("lock_entered", locked_o, 1);
    btn_up_i = 1'b0; tick(10);
    check("lock_one_left", locked_o, 1);
    btn_down_i = 1'b0; tick(10);
    check("lock_released", locked_o, 0);
    btn_up_i = 1'b1; tick(12);
    btn_up_i = 1'b0; tick(10);
    check("lock_seq_pulses", pulses_seen - base, 2);

    // Simultaneous press: locked from edge 7, no pulse.
    base = pulses_seen;
    btn_up_i = 1'b1; btn_down_i = 1'b1;
    tick(7);
    check("both_locked_edge6", locked_o, 0);
    tick(1);
    check("both_locked_edge7", locked_o, 1);
    btn_up_i = 1'b0; btn_down_i = 1'b0;
    tick(10);
    check("both_pulses", pulses_seen - base, 0);

    // Long hold: debounced release lands between offsets 36 and 40.
    base = pulses_seen;
    btn_up_i = 1'b1; tick(40);
    btn_up_i = 1'b0; tick(12);
`ifdef COUNTER_CTRL_AUTOREPEAT_EN
    exp_rpt = 7;
`else
    exp_rpt = 1;
`endif
    check("hold_pulses", pulses_seen - base, exp_rpt);

    // Random button levels and hold lengths, with the odd reset.
    repeat (60) begin
      btn_up_i   = 1'($urandom_range(0, 1));
      btn_down_i = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 19) == 0) rst = 1'b1;
      tick(1);
      rst = 1'b0;
      tick($urandom_range(0, 14));
    end
    btn_up_i = 1'b0; btn_down_i = 1'b0;
    tick(20);
    check("leftover_expected", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ucsbece152a_counter_ctrl.md
Name: ucsbece152a_counter_ctrl

Overview:
- Drives the up/down counter's command interface (enable, direction) from two raw pushbuttons, BTN_UP and BTN_DOWN.
- Synchronizes and debounces each button, then detects presses.
- Each accepted press becomes a single-cycle enable pulse, with a direction bit that stays stable around the pulse.
- Sits between the board buttons and the counter in the lab top level. Its outputs wire directly to the counter's enable and direction inputs.

Parameters:
- DEBOUNCE_CYCLES, 8: consecutive stable cycles needed before a debounced level changes. Legal range 1..2^16-1.
- REPEAT_DELAY, 16: cycles from the first pulse to the first auto-repeat pulse. Used only when the optional feature is enabled.
- REPEAT_PERIOD, 4: cycles between later auto-repeat pulses. Used only when the optional feature is enabled.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- btn_up_i  input  1  raw, asynchronous, bouncy "count up" button, active-high.
- btn_down_i  input  1  raw, asynchronous, bouncy "count down" button, active-high.
- enable_o  output  1  single-cycle pulse requesting one counter step.
- dir_o  output  1  step direction: 0 = up (increment), 1 = down (decrement). Matches the counter's direction encoding.
- locked_o  output  1  high while both buttons are debounced-pressed (lockout state).

Behaviour:
- Reset (async, active-high): all synchronizer flops, debounced levels and debounce counters clear to 0. FSM goes to IDLE.
- Output reset values: enable_o=0, dir_o=0, locked_o=0. Reset asserted mid-press aborts everything. After release of reset, a button still held must be re-debounced before it produces a pulse.
- Synchronizer: each raw input passes through 2 flops.
- Debounce, per button:
  - The counter increments while the synchronized level differs from the debounced level.
  - It clears on any cycle where they are equal.
  - When the count reaches DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES is never seen.
- Latency: a raw input rising before clock edge 0 and held makes enable_o high for exactly the cycle after edge DEBOUNCE_CYCLES+3.
- FSM states and transitions (db_up and db_down are the debounced levels):
  - IDLE: db_up rising and db_down low → one pulse with dir_o=0, go to HELD_UP.
  - IDLE: db_down rising and db_up low → one pulse with dir_o=1, go to HELD_DOWN.
  - IDLE: both rise in the same cycle → no pulse, go to LOCK.
  - HELD_UP / HELD_DOWN: held button releases and the other is low → IDLE, no pulse.
  - HELD_UP / HELD_DOWN: the other button becomes pressed → LOCK, no pulse.
  - LOCK: locked_o=1. Stays until both are released, then IDLE. A single remaining button never pulses from LOCK; it must be released and pressed again.
- dir_o is registered. It updates in the same cycle enable_o rises and holds its value between pulses, so it is never changed while enable_o=1.
- enable_o is never high on two consecutive cycles.

Optional Feature:
- Macro: COUNTER_CTRL_AUTOREPEAT_EN.
- Defined:
  - In HELD_UP or HELD_DOWN, a repeat timer starts at the initial pulse.
  - The first repeat pulse comes REPEAT_DELAY cycles after the initial pulse, then one every REPEAT_PERIOD cycles while still held, with the same dir_o.
  - The timer clears on leaving the HELD state and on reset.
  - Timer width is clog2 of max(REPEAT_DELAY, REPEAT_PERIOD)+1.
- Not defined: exactly one pulse per press. Timer logic and the REPEAT_* parameters have no effect.

Decomposition:
- Package ucsbece152a_counter_ctrl_pkg holds:
  - state enum type ctrl_state_t: IDLE, HELD_UP, HELD_DOWN, LOCK.
  - constants DIR_UP=1'b0 and DIR_DOWN=1'b1.
- Sub-module ucsbece152a_debounce: 2-flop synchronizer plus debounce counter. Parameter DEBOUNCE_CYCLES; ports clk, rst, raw_i, level_o, rise_o (single-cycle debounced rising edge). Instantiated once per button.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=16, REPEAT_PERIOD=4):
- Reset held 3 cycles with both buttons high → enable_o=0, dir_o=0, locked_o=0 throughout. After release: one up-pulse at edge 7 only if btn_down_i is low.
- btn_up_i raised before edge 0 and held 20 cycles → enable_o=1 only in the cycle after edge 7, with dir_o=0. Drive 5 pulses → counter model reads 5.
- btn_down_i bounces 1,0,1,0 on alternate cycles, then settles high → no pulse during bounce. One pulse with dir_o=1 comes 4+3 cycles after settling. Counter model wraps from 0 to 7 (WIDTH=3).
- btn_up_i held, then btn_down_i pressed → locked_o=1 after debounce, no pulse. Release up only → still LOCK, no pulse. Release down → IDLE. Press up again → one pulse.
- Both buttons raised on the same edge → no pulse, locked_o=1 at edge 7.
- With COUNTER_CTRL_AUTOREPEAT_EN, hold btn_up_i 40 cycles after the first pulse → pulses at offsets 0, 16, 20, 24, 28, 32, 36, all with dir_o=0. Without the macro → the offset-0 pulse only.
